// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: bit-selection tables, per-round shift
// amounts and the 28-bit half-key rotate helpers.
package des_pkg;

    localparam int KEY_W = 64;
    localparam int CD_W  = 28;
    localparam int SK_W  = 48;

    // Left-rotate amount applied to produce C(i+1)/D(i+1), indexed from 0.
    localparam logic [0:15][1:0] SHIFT = {
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // DES 1-based bit numbers; entry 0 is output bit 1.
    localparam logic [0:55][6:0] PC1_IDX = {
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd63, 7'd55, 7'd47, 7'd39,
        7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38,
        7'd30, 7'd22, 7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37,
        7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    localparam logic [0:47][6:0] PC2_IDX = {
        7'd14, 7'd17, 7'd11, 7'd24, 7'd1,  7'd5,  7'd3,  7'd28,
        7'd15, 7'd6,  7'd21, 7'd10, 7'd23, 7'd19, 7'd12, 7'd4,
        7'd26, 7'd8,  7'd16, 7'd7,  7'd27, 7'd20, 7'd13, 7'd2,
        7'd41, 7'd52, 7'd31, 7'd37, 7'd47, 7'd55, 7'd30, 7'd40,
        7'd51, 7'd45, 7'd33, 7'd48, 7'd44, 7'd49, 7'd39, 7'd56,
        7'd34, 7'd53, 7'd46, 7'd42, 7'd50, 7'd36, 7'd29, 7'd32
    };

    function automatic logic [CD_W-1:0] rol28(input logic [CD_W-1:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[CD_W-2:0], x[CD_W-1]};
            2'd2:    return {x[CD_W-3:0], x[CD_W-1:CD_W-2]};
            default: return x;
        endcase
    endfunction

    function automatic logic [CD_W-1:0] ror28(input logic [CD_W-1:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[CD_W-1:1]};
            2'd2:    return {x[1:0], x[CD_W-1:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-offer and subkey-stream handshake bundle between the key source,
// the key schedule and the round datapath.
interface des_key_schedule_if;
    import des_pkg::*;

    logic [KEY_W-1:0] key_in;
    logic             decrypt;
    logic             key_valid;
    logic             key_ready;
    logic [SK_W-1:0]  sk_out;
    logic [3:0]       sk_round;
    logic             sk_valid;
    logic             sk_ready;
    logic             sk_last;
    logic             busy;

    modport master (
        output key_in, decrypt, key_valid, sk_ready,
        input  key_ready, sk_out, sk_round, sk_valid, sk_last, busy
    );

    modport slave (
        input  key_in, decrypt, key_valid, sk_ready,
        output key_ready, sk_out, sk_round, sk_valid, sk_last, busy
    );

endinterface

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: selects the 48 subkey bits from the 56-bit C/D pair.
module des_pc2
    import des_pkg::*;
(
    input  logic [2*CD_W-1:0] cd,
    output logic [SK_W-1:0]   sk
);

    for (genvar i = 0; i < SK_W; i++) begin : g_pc2
        assign sk[SK_W-1-i] = cd[2*CD_W - PC2_IDX[i]];
    end

    // The eight C/D bits PC-2 discards (DES bits 9,18,22,25,35,38,43,54).
    logic unused_cd;
    assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one 64-bit key in, sixteen 48-bit subkeys out,
// one per sk handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule
    import des_pkg::*;
#(
    parameter int NROUNDS = 16,
    parameter bit REG_OUT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    des_key_schedule_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [3:0] LAST_CNT = 4'(NROUNDS - 1);

    logic [1:0]      state_q, state_d;
    logic [CD_W-1:0] c_q, c_d;
    logic [CD_W-1:0] d_q, d_d;
    logic            dir_q, dir_d;
    logic [3:0]      cnt_q, cnt_d;

    logic [2*CD_W-1:0] pc1_cd;
    logic [2*CD_W-1:0] pc2_in;
    logic [SK_W-1:0]   pc2_sk;

    for (genvar i = 0; i < 2*CD_W; i++) begin : g_pc1
        assign pc1_cd[2*CD_W-1-i] = bus.key_in[KEY_W - PC1_IDX[i]];
    end

    // Parity bits (DES bits 8,16,..,64) never reach the schedule.
    logic unused_parity;
    assign unused_parity = ^{bus.key_in[56], bus.key_in[48], bus.key_in[40], bus.key_in[32],
                             bus.key_in[24], bus.key_in[16], bus.key_in[8],  bus.key_in[0]};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.key_valid) begin
                    c_d     = pc1_cd[2*CD_W-1:CD_W];
                    d_d     = pc1_cd[CD_W-1:0];
                    dir_d   = bus.decrypt;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Decrypt starts at C16/D16, which equals C0/D0 after 28 total shifts.
                if (!dir_q) begin
                    c_d = rol28(c_q, SHIFT[0]);
                    d_d = rol28(d_q, SHIFT[0]);
                end
                state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.sk_ready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (dir_q) begin
                        c_d = ror28(c_q, SHIFT[LAST_CNT - cnt_q]);
                        d_d = ror28(d_q, SHIFT[LAST_CNT - cnt_q]);
                    end else begin
                        c_d = rol28(c_q, SHIFT[cnt_q + 4'd1]);
                        d_d = rol28(d_q, SHIFT[cnt_q + 4'd1]);
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered output looks at next-state C/D so both variants share latency.
    if (REG_OUT) begin : g_reg_out
        logic [SK_W-1:0] sk_q, sk_d;

        assign pc2_in = {c_d, d_d};

        always_comb begin
            sk_d = pc2_sk;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sk_q <= '0;
            end else begin
                sk_q <= sk_d;
            end
        end

        assign bus.sk_out = sk_q;
    end else begin : g_comb_out
        assign pc2_in     = {c_q, d_q};
        assign bus.sk_out = pc2_sk;
    end

    des_pc2 u_pc2 (
        .cd (pc2_in),
        .sk (pc2_sk)
    );

    assign bus.key_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.sk_valid  = (state_q == S_RUN);
    assign bus.sk_round  = dir_q ? (LAST_CNT - cnt_q) : cnt_q;
    assign bus.sk_last   = (state_q == S_RUN) && (cnt_q == LAST_CNT);

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1
// key and its published subkey table.
module tb_des_key_schedule;
    import des_pkg::*;

    localparam logic [63:0] KEY    = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] PARITY = 64'h0101_0101_0101_0101;

    logic clk = 1'b0;
    logic rst;

    des_key_schedule_if bus ();

    des_key_schedule #(
        .NROUNDS (16),
        .REG_OUT (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0] k_enc [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic [47:0] cap_k [16];
    logic [3:0]  cap_r [16];
    logic [15:0] cap_l;
    logic [15:0] cap_v;

    // Presents a key for exactly one accept edge; returns at the negedge in LOAD.
    task automatic offer_key(input logic [63:0] k, input logic dec);
        int t = 0;
        while (!bus.key_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (bus.key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL offer_timeout: key_ready=%b after %0d cycles, required 1", bus.key_ready, t);
        end
        bus.key_in    = k;
        bus.decrypt   = dec;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_in    = 64'hDEAD_BEEF_0BAD_F00D;
        bus.decrypt   = ~dec;
    endtask

    // Captures 16 cycles with sk_ready held high, starting one edge after LOAD.
    task automatic collect();
        bus.sk_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cap_v[i] = bus.sk_valid;
            cap_k[i] = bus.sk_out;
            cap_r[i] = bus.sk_round;
            cap_l[i] = bus.sk_last;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.key_ready !== 1'b1 || bus.sk_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/valid/busy=%b%b%b, required 100",
                     bus.key_ready, bus.sk_valid, bus.busy);
        end
        n_checks++;
        if (bus.sk_out !== 48'h0 || bus.sk_round !== 4'd0 || bus.sk_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: sk_out=%h round=%0d last=%b, required 0/0/0",
                     bus.sk_out, bus.sk_round, bus.sk_last);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.key_ready !== 1'b1 || bus.busy !== 1'b0 || bus.sk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready/busy/valid=%b%b%b, required 100",
                     bus.key_ready, bus.busy, bus.sk_valid);
        end
    endtask

    task automatic test_encrypt();
        offer_key(KEY, 1'b0);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.sk_valid !== 1'b0 || bus.key_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL enc_load: busy/valid/ready=%b%b%b, required 100",
                     bus.busy, bus.sk_valid, bus.key_ready);
        end
        collect();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (cap_v[i] !== 1'b1 || cap_k[i] !== k_enc[i]) begin
                n_fail++;
                $display("FAIL enc_k%0d: valid=%b sk_out=%h, required 1 %h", i + 1, cap_v[i], cap_k[i], k_enc[i]);
            end
            n_checks++;
            if (cap_r[i] !== 4'(i) || cap_l[i] !== (i == 15)) begin
                n_fail++;
                $display("FAIL enc_tag%0d: round=%0d last=%b, required %0d %b", i + 1, cap_r[i], cap_l[i], i, i == 15);
            end
        end
        n_checks++;
        if (bus.sk_valid !== 1'b0 || bus.key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL enc_done: valid=%b ready=%b, required 0 1", bus.sk_valid, bus.key_ready);
        end
    endtask

    task automatic test_decrypt();
        offer_key(KEY, 1'b1);
        collect();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (cap_v[i] !== 1'b1 || cap_k[i] !== k_enc[15-i]) begin
                n_fail++;
                $display("FAIL dec_emit%0d: valid=%b sk_out=%h, required 1 %h", i, cap_v[i], cap_k[i], k_enc[15-i]);
            end
            n_checks++;
            if (cap_r[i] !== 4'(15 - i) || cap_l[i] !== (i == 15)) begin
                n_fail++;
                $display("FAIL dec_tag%0d: round=%0d last=%b, required %0d %b", i, cap_r[i], cap_l[i], 15 - i, i == 15);
            end
        end
    endtask

    task automatic test_backpressure();
        int          got     = 0;
        int          cyc     = 0;
        logic        stalled = 1'b0;
        logic [47:0] prev_k  = '0;
        logic [3:0]  prev_r  = '0;
        logic        prev_l  = 1'b0;
        offer_key(KEY, 1'b0);
        while (got < 16 && cyc < 300) begin
            bus.sk_ready = (cyc < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            if (bus.sk_valid) begin
                if (stalled) begin
                    n_checks++;
                    if (bus.sk_out !== prev_k || bus.sk_round !== prev_r || bus.sk_last !== prev_l) begin
                        n_fail++;
                        $display("FAIL bp_stable: sk_out=%h round=%0d last=%b, required %h %0d %b",
                                 bus.sk_out, bus.sk_round, bus.sk_last, prev_k, prev_r, prev_l);
                    end
                end
                n_checks++;
                if (bus.sk_out !== k_enc[got] || bus.sk_round !== 4'(got)) begin
                    n_fail++;
                    $display("FAIL bp_seq%0d: sk_out=%h round=%0d, required %h %0d",
                             got, bus.sk_out, bus.sk_round, k_enc[got], got);
                end
                if (bus.sk_ready) got++;
            end
            stalled = bus.sk_valid && !bus.sk_ready;
            prev_k  = bus.sk_out;
            prev_r  = bus.sk_round;
            prev_l  = bus.sk_last;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (got != 16 || bus.sk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_count: handshakes=%0d valid_after=%b, required 16 0", got, bus.sk_valid);
        end
        bus.sk_ready = 1'b1;
    endtask

    task automatic test_key_valid_held();
        int viol = 0;
        int t    = 0;
        offer_key(KEY, 1'b0);
        bus.key_valid = 1'b1;
        bus.key_in    = ONES;
        bus.decrypt   = 1'b0;
        bus.sk_ready  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.key_ready !== 1'b0 || bus.sk_out !== k_enc[i]) viol++;
        end
        n_checks++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL hold_run: %0d cycles with key_ready high or wrong subkey, required 0", viol);
        end
        @(negedge clk);
        n_checks++;
        if (bus.key_ready !== 1'b1 || bus.sk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_idle: ready=%b valid=%b, required 1 0", bus.key_ready, bus.sk_valid);
        end
        @(negedge clk);
        bus.key_valid = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.sk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_load: busy=%b valid=%b, required 1 0", bus.busy, bus.sk_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus.sk_valid !== 1'b1 || bus.sk_out !== 48'hFFFF_FFFF_FFFF || bus.sk_round !== 4'd0) begin
            n_fail++;
            $display("FAIL hold_second_k1: valid=%b sk_out=%h round=%0d, required 1 ffffffffffff 0",
                     bus.sk_valid, bus.sk_out, bus.sk_round);
        end
        while (!bus.key_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset_mid_run();
        int t = 0;
        offer_key(KEY, 1'b0);
        bus.sk_ready = 1'b1;
        @(negedge clk);
        while (bus.sk_round !== 4'd6 && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (bus.sk_valid !== 1'b1 || bus.sk_round !== 4'd6 || bus.sk_out !== k_enc[6]) begin
            n_fail++;
            $display("FAIL rst_reach_k7: valid=%b round=%0d sk_out=%h, required 1 6 %h",
                     bus.sk_valid, bus.sk_round, bus.sk_out, k_enc[6]);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.key_ready !== 1'b1 || bus.sk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sk_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async_ctrl: ready/valid/busy/last=%b%b%b%b, required 1000",
                     bus.key_ready, bus.sk_valid, bus.busy, bus.sk_last);
        end
        n_checks++;
        if (bus.sk_out !== 48'h0 || bus.sk_round !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_async_data: sk_out=%h round=%0d, required 0 0", bus.sk_out, bus.sk_round);
        end
        @(negedge clk);
        rst = 1'b0;
        offer_key(64'h0, 1'b0);
        collect();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (cap_v[i] !== 1'b1 || cap_k[i] !== 48'h0 || cap_r[i] !== 4'(i)) begin
                n_fail++;
                $display("FAIL rst_zero_k%0d: valid=%b sk_out=%h round=%0d, required 1 0 %0d",
                         i + 1, cap_v[i], cap_k[i], cap_r[i], i);
            end
        end
    endtask

    task automatic test_parity_ignored();
        offer_key(KEY ^ PARITY, 1'b0);
        collect();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (cap_v[i] !== 1'b1 || cap_k[i] !== k_enc[i]) begin
                n_fail++;
                $display("FAIL parity_k%0d: valid=%b sk_out=%h, required 1 %h", i + 1, cap_v[i], cap_k[i], k_enc[i]);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.key_in    = '0;
        bus.decrypt   = 1'b0;
        bus.key_valid = 1'b0;
        bus.sk_ready  = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_key_valid_held();
        test_reset_mid_run();
        test_parity_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
